// File: rtl/fir_pkg.sv
// Shared constants, state encoding and output saturation for the serial 32-tap FIR engine.
package fir_pkg;

    localparam int TAPS  = 32;
    localparam int AW    = 5;
    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int ACCW  = DW + CW + AW;
    localparam int SHIFT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic signed [ACCW-1:0] SAT_MAX    = ACCW'((1 << (DW - 1)) - 1);
    localparam logic signed [ACCW-1:0] SAT_MIN    = ~SAT_MAX;
    localparam logic signed [ACCW-1:0] ROUND_HALF = ACCW'(1) << (SHIFT - 1);

    function automatic logic signed [DW-1:0] sat_dw(input logic signed [ACCW-1:0] r);
        if (r > SAT_MAX) begin
            return SAT_MAX[DW-1:0];
        end else if (r < SAT_MIN) begin
            return SAT_MIN[DW-1:0];
        end
        return r[DW-1:0];
    endfunction

endpackage

// File: rtl/fir_sample_buf.sv
// Circular sample history: one registered write port, one combinational read port.
module fir_sample_buf
    import fir_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [TAPS];

    // Cleared on reset so startup outputs see a zero history.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < TAPS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fir_serial_mac.sv
// Serial 32-tap FIR: accepts one sample, runs 32 MAC cycles against an external
// combinational coefficient ROM, then emits one rounded, saturated output.
//   state | meaning
//   IDLE  | ready for a sample; write it and clear the accumulator on accept
//   MAC   | tap k_q: acc += coef[k] * buf[newest - k]
//   DONE  | round, saturate, register dout and pulse out_valid
module fir_serial_mac
    import fir_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [AW-1:0] coef_addr,
    input  logic [CW-1:0] coef,
    output logic [DW-1:0] dout,
    output logic          out_valid,
    output logic          overrun
);

    state_e                    state_q;
    logic [AW-1:0]             k_q;
    logic [AW-1:0]             wptr_q;
    logic [AW-1:0]             newest_q;
    logic [AW-1:0]             rd_addr;
    logic signed [ACCW-1:0]    acc_q;
    logic signed [ACCW-1:0]    acc_d;
    logic signed [ACCW-1:0]    acc_rnd;
    logic signed [ACCW-1:0]    acc_shr;
    logic signed [DW+CW-1:0]   prod;
    logic signed [DW-1:0]      sample;
    logic [DW-1:0]             dout_q;
    logic                      out_valid_q;
    logic                      overrun_q;
    logic                      accept;

    assign in_ready  = (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign coef_addr = (state_q == MAC) ? k_q : '0;
    assign rd_addr   = newest_q - k_q;

    fir_sample_buf u_buf (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .we_i    (accept),
        .waddr_i (wptr_q),
        .wdata_i (din),
        .raddr_i (rd_addr),
        .rdata_o (sample)
    );

    // Accumulator is wide enough for 32 full-scale products, so no wrap is possible.
    assign prod    = (DW+CW)'($signed(coef)) * (DW+CW)'(sample);
    assign acc_d   = acc_q + ACCW'(prod);
    assign acc_rnd = acc_q + ROUND_HALF;
    assign acc_shr = acc_rnd >>> SHIFT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            wptr_q      <= '0;
            newest_q    <= '0;
            acc_q       <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (in_valid && !in_ready) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        newest_q <= wptr_q;
                        wptr_q   <= wptr_q + AW'(1);
                        acc_q    <= '0;
                        k_q      <= '0;
                        state_q  <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    if (k_q == AW'(TAPS - 1)) begin
                        state_q <= DONE;
                    end else begin
                        k_q <= k_q + AW'(1);
                    end
                end
                DONE: begin
                    dout_q      <= sat_dw(acc_shr);
                    out_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dout      = dout_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_fir_serial_mac.sv
// Bench for fir_serial_mac: bench-side coefficient ROM, reference model feeding a
// scoreboard queue, impulse table plus hand-written handshake/overrun/reset sequences.
module tb_fir_serial_mac;

    localparam int N = 32;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [15:0] din      = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  coef_addr;
    logic [15:0] coef;
    logic [15:0] dout;
    logic        out_valid;
    logic        overrun;

    logic signed [15:0] rom_tbl [N];
    logic               rom_max = 1'b0;

    // Stand-in for the highpass coefficient ROM (taps 0..2 and 16 match the reference ROM).
    int coef_init [N] = '{49, 60, 85, 112, 131, 128, 85, -14, -180, -418, -722,
                          -1073, -1440, -1783, -2064, -2247, -20810, -2247, -2064,
                          -1783, -1440, -1073, -722, -418, -180, -14, 85, 128, 131,
                          112, 85, 60};

    always #5 clk = ~clk;

    assign coef = rom_max ? 16'h7FFF : rom_tbl[coef_addr];

    fir_serial_mac dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .coef_addr (coef_addr),
        .coef      (coef),
        .dout      (dout),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    int          checks  = 0;
    int          errors  = 0;
    int          out_cnt = 0;
    logic [15:0] last_dout = '0;
    logic [15:0] exp_q [$];
    int          hist [N];
    int          mptr = 0;

    typedef struct {
        logic [15:0] din;
        bit          chk;
        logic [15:0] exp;
    } vec_t;

    vec_t imp_vec [N];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int coef_of(input int a);
        if (rom_max) return 32767;
        return int'(rom_tbl[a]);
    endfunction

    function automatic logic [15:0] model_step(input logic [15:0] s);
        longint acc = 0;
        longint r;
        int     newest;
        hist[mptr] = int'($signed(s));
        newest     = mptr;
        mptr       = (mptr + 1) % N;
        for (int k = 0; k < N; k++) begin
            acc += longint'(coef_of(k)) * longint'(hist[(newest - k) & (N - 1)]);
        end
        r = (acc + 64'sd16384) >>> 15;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) hist[i] = 0;
        mptr = 0;
    endfunction

    always @(negedge clk) begin
        if (out_valid) begin
            out_cnt++;
            last_dout = dout;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got dout 0x%0h expected no output pulse", dout);
            end else begin
                check("scoreboard", int'(dout), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic send(input logic [15:0] s);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end else begin
            in_valid = 1'b1;
            din      = s;
            exp_q.push_back(model_step(s));
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic wait_out(input int prev);
        int t = 0;
        while (out_cnt == prev && t < 100) begin
            @(posedge clk);
            #2;
            t++;
        end
        if (out_cnt == prev) begin
            checks++;
            errors++;
            $display("FAIL out_timeout: got no out_valid expected one within 100 cycles");
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk);
            #2;
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic run_impulse();
        int prev;
        for (int i = 0; i < N; i++) begin
            prev = out_cnt;
            send(imp_vec[i].din);
            wait_out(prev);
            if (imp_vec[i].chk) begin
                check($sformatf("impulse_out%0d", i), int'(last_dout), int'(imp_vec[i].exp));
            end
        end
        wait_drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          bad_rdy;
        int          bad_ov;
        int          bad_addr;
        int          cnt_before;
        logic [15:0] rnd;

        for (int i = 0; i < N; i++) begin
            rom_tbl[i]      = 16'(coef_init[i]);
            imp_vec[i].din  = (i == 0) ? 16'h7FFF : 16'h0000;
            imp_vec[i].chk  = 1'b0;
            imp_vec[i].exp  = '0;
        end
        imp_vec[0].chk  = 1'b1; imp_vec[0].exp  = 16'h0031;
        imp_vec[1].chk  = 1'b1; imp_vec[1].exp  = 16'h003C;
        imp_vec[2].chk  = 1'b1; imp_vec[2].exp  = 16'h0055;
        imp_vec[16].chk = 1'b1; imp_vec[16].exp = 16'hAEB7;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_dout", dout, 0);
        check("rst_coef_addr", coef_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_impulse();

        // Handshake timing around one sample and a back-to-back follower.
        @(negedge clk);
        in_valid = 1'b1;
        din      = 16'h0100;
        exp_q.push_back(model_step(16'h0100));
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("hs_ready_E0", in_ready, 0);
        bad_rdy = 0; bad_ov = 0; bad_addr = 0;
        for (int i = 1; i <= 33; i++) begin
            @(posedge clk);
            #1;
            if (i < 33) begin
                if (in_ready) bad_rdy++;
                if (out_valid) bad_ov++;
                if (coef_addr != ((i < 32) ? 5'(i) : 5'd0)) bad_addr++;
            end
        end
        check("hs_ready_low", bad_rdy, 0);
        check("hs_valid_early", bad_ov, 0);
        check("hs_coef_addr", bad_addr, 0);
        check("hs_valid_E33", out_valid, 1);
        check("hs_ready_E33", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b1;
        din      = 16'h0200;
        exp_q.push_back(model_step(16'h0200));
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("hs_accept_E34", in_ready, 0);
        check("hs_valid_E34", out_valid, 0);
        check("hs_no_overrun", overrun, 0);
        wait_drain();

        // Overrun: a sample offered during MAC is dropped and the flag sticks.
        check("ovr_clear", overrun, 0);
        @(negedge clk);
        in_valid = 1'b1;
        din      = 16'h0400;
        exp_q.push_back(model_step(16'h0400));
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        din      = 16'h1234;
        @(posedge clk);
        #1 in_valid = 1'b0;
        din = '0;
        check("ovr_set", overrun, 1);
        wait_drain();
        send(16'h0010);
        send(16'hFFF0);
        send(16'h4000);
        wait_drain();
        check("ovr_sticky", overrun, 1);

        rom_max = 1'b1;
        for (int i = 0; i < N; i++) send(16'h7FFF);
        wait_drain();
        check("sat_pos", last_dout, 16'h7FFF);
        for (int i = 0; i < N; i++) send(16'h8000);
        wait_drain();
        check("sat_neg", last_dout, 16'h8000);
        rom_max = 1'b0;

        // Reset in the middle of a MAC run.
        cnt_before = out_cnt;
        @(negedge clk);
        in_valid = 1'b1;
        din      = 16'h7FFF;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_in_ready", in_ready, 1);
        check("mrst_dout", dout, 0);
        check("mrst_overrun", overrun, 0);
        check("mrst_coef_addr", coef_addr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("mrst_no_pulse", out_cnt, cnt_before);
        model_reset();
        run_impulse();

        // Wrap-around of the read/write pointers.
        for (int i = 0; i < 40; i++) begin
            rnd = 16'($urandom);
            send(rnd);
        end
        wait_drain();

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
